mvm_job_driver: RTL

- Initiator-side sequencer for the mvm_K_1_B_1 matrix-vector multiplier.
- Accepts one job (K*K matrix words, row-major, then K vector words) on a valid/ready input stream and buffers it internally.
- Replays the job to the MVM core as gap-free load/start sequences, then captures the K results into an output buffer drained through a valid/ready stream.
- Sits between the system data mover and the MVM core.

---
 rtl/mvm_job_driver.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mvm_job_driver.sv
// Initiator-side sequencer for the mvm_K_1_B_1 core: buffers one job, replays it as
// gap-free load/start sequences and drains K results. Optional feature: MVM_DRV_TIMEOUT_EN.
module mvm_job_driver #(
    parameter int K       = 4,
    parameter int B       = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic [B-1:0]   i_s_data,
    input  logic           i_s_valid,
    output logic           o_s_ready,
    output logic           o_loadMatrix,
    output logic           o_loadVector,
    output logic           o_start,
    input  logic           i_done,
    output logic [B-1:0]   o_mvm_data_in,
    input  logic [2*B-1:0] i_mvm_data_out,
    output logic [2*B-1:0] o_m_data,
    output logic           o_m_valid,
    input  logic           i_m_ready,
    output logic           o_busy,
    output logic           o_err
);
    localparam int NW = K*K + K;
    localparam int CW = (NW > 1) ? $clog2(NW) : 1;
    localparam int RW = (K > 1) ? $clog2(K) : 1;

    localparam logic [CW-1:0] JOB_LAST = CW'(NW - 1);
    localparam logic [CW-1:0] MAT_LAST = CW'(K*K - 1);
    localparam logic [CW-1:0] CAP_LAST = CW'(K - 1);
    localparam logic [RW-1:0] RES_LAST = RW'(K - 1);

    typedef enum logic [3:0] {
        S_COLLECT, S_LM_PULSE, S_LM_DATA, S_LV_GAP, S_LV_PULSE, S_LV_DATA,
        S_ST_GAP, S_START, S_WAIT_DONE, S_CAPTURE, S_DRAIN
    } state_t;

    state_t         r_state, w_next;
    logic [CW-1:0]  r_cnt, w_cnt_nxt;
    logic [RW-1:0]  r_rd, w_rd_nxt;
    logic [B-1:0]   r_job [NW];
    logic [2*B-1:0] r_res [K];
    logic           w_xfer, w_pop, w_timeout;

    assign w_xfer = (r_state == S_COLLECT) && i_s_valid;
    assign w_pop  = (r_state == S_DRAIN) && i_m_ready;

`ifdef MVM_DRV_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] r_to;
    logic          r_err;

    assign w_timeout = (r_state == S_WAIT_DONE) && !i_done && (r_to == TW'(TIMEOUT - 1));
    assign o_err     = r_err;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_to  <= '0;
            r_err <= 1'b0;
        end else begin
            r_to <= (r_state == S_WAIT_DONE && !i_done) ? r_to + 1'b1 : '0;
            if (w_timeout) r_err <= 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign o_err     = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_COLLECT;
            r_cnt   <= '0;
            r_rd    <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_nxt;
            r_rd    <= w_rd_nxt;
        end
    end

    // Storage needs no reset: only state-qualified reads ever reach the outputs.
    always_ff @(posedge i_clk) begin
        if (w_xfer) r_job[r_cnt] <= i_s_data;
        if (r_state == S_CAPTURE) r_res[r_cnt[RW-1:0]] <= i_mvm_data_out;
    end

    // r_cnt is shared: job write pointer, replay index (matrix then vector), capture index.
    always_comb begin
        w_next    = r_state;
        w_cnt_nxt = r_cnt;
        w_rd_nxt  = r_rd;
        unique case (r_state)
            S_COLLECT: begin
                if (w_xfer) begin
                    if (r_cnt == JOB_LAST) begin
                        w_next    = S_LM_PULSE;
                        w_cnt_nxt = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            S_LM_PULSE: w_next = S_LM_DATA;
            S_LM_DATA: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == MAT_LAST) w_next = S_LV_GAP;
            end
            S_LV_GAP:   w_next = S_LV_PULSE;
            S_LV_PULSE: w_next = S_LV_DATA;
            S_LV_DATA: begin
                if (r_cnt == JOB_LAST) begin
                    w_next    = S_ST_GAP;
                    w_cnt_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_ST_GAP: w_next = S_START;
            S_START:  w_next = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (i_done)         w_next = S_CAPTURE;
                else if (w_timeout) w_next = S_COLLECT;
            end
            S_CAPTURE: begin
                if (r_cnt == CAP_LAST) begin
                    w_next    = S_DRAIN;
                    w_cnt_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_DRAIN: begin
                if (w_pop) begin
                    if (r_rd == RES_LAST) begin
                        w_next   = S_COLLECT;
                        w_rd_nxt = '0;
                    end else begin
                        w_rd_nxt = r_rd + 1'b1;
                    end
                end
            end
            default: begin
                w_next    = S_COLLECT;
                w_cnt_nxt = '0;
                w_rd_nxt  = '0;
            end
        endcase
    end

    always_comb begin
        o_s_ready     = (r_state == S_COLLECT);
        o_loadMatrix  = (r_state == S_LM_PULSE);
        o_loadVector  = (r_state == S_LV_PULSE);
        o_start       = (r_state == S_START);
        o_mvm_data_in = '0;
        if (r_state == S_LM_DATA || r_state == S_LV_DATA) o_mvm_data_in = r_job[r_cnt];
        o_m_valid     = (r_state == S_DRAIN);
        o_m_data      = '0;
        if (r_state == S_DRAIN) o_m_data = r_res[r_rd];
        o_busy        = !(r_state == S_COLLECT && r_cnt == '0);
    end

endmodule
